clusterv_main_sram_arb: RTL and testbench

Round-robin arbiter sharing the single read/write port of the cluster main SRAM (32-bit words, 10-bit word address, byte enables) among N_REQ cluster requesters. Sits between the per-core memory interfaces and the main-SRAM wrapper target port. It issues at most one SRAM access per clock and returns a response to the winning requester exactly one cycle later. An optional lock gives one requester back-to-back atomic read-modify-write sequences, bounded by a timeout.

---
 rtl/clusterv_sram_arb_pkg.sv | 15 +
 rtl/clusterv_main_sram_arb_if.sv | 41 ++++
 rtl/clusterv_rr_arb.sv | 32 +++
 rtl/clusterv_main_sram_arb.sv | 117 +++++++++++
 tb/tb_clusterv_main_sram_arb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/clusterv_sram_arb_pkg.sv
// Shared constants and helpers for the cluster main-SRAM arbiter.
// Default parameters and requester-index width.
package clusterv_sram_arb_pkg;

  localparam int N_REQ_DEF        = 4;
  localparam int ADDR_W_DEF       = 10;
  localparam int DATA_W_DEF       = 32;
  localparam int LOCK_TIMEOUT_DEF = 15;
  localparam int LOCK_CNT_W       = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clusterv_main_sram_arb_if.sv
// Bundle of requester-side and SRAM-target-side signals for the main-SRAM arbiter.
// The arbiter uses the slave view; the requesters plus SRAM wrapper use the master view.
interface clusterv_main_sram_arb_if
  import clusterv_sram_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  localparam int BE_W = DATA_W / 8;

  logic [N_REQ-1:0]        rq_valid;
  logic [N_REQ-1:0]        rq_ready;
  logic [N_REQ-1:0]        rq_write;
  logic [N_REQ-1:0]        rq_lock;
  logic [N_REQ*ADDR_W-1:0] rq_addr;
  logic [N_REQ*BE_W-1:0]   rq_byte_en;
  logic [N_REQ*DATA_W-1:0] rq_wdata;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic [ADDR_W-1:0]       t_addr;
  logic                    t_read_en;
  logic                    t_write_en;
  logic [BE_W-1:0]         t_byte_en;
  logic [DATA_W-1:0]       t_write_data;
  logic [DATA_W-1:0]       t_read_data;

  modport slave (
    input  rq_valid, rq_write, rq_lock, rq_addr, rq_byte_en, rq_wdata, t_read_data,
    output rq_ready, rsp_valid, rsp_rdata,
           t_addr, t_read_en, t_write_en, t_byte_en, t_write_data
  );

  modport master (
    output rq_valid, rq_write, rq_lock, rq_addr, rq_byte_en, rq_wdata, t_read_data,
    input  rq_ready, rsp_valid, rsp_rdata,
           t_addr, t_read_en, t_write_en, t_byte_en, t_write_data
  );

endinterface

// File: rtl/clusterv_rr_arb.sv
// Combinational round-robin picker: first eligible index after rr_last, wrapping.
module clusterv_rr_arb
  import clusterv_sram_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [IDX_W-1:0] rr_last,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  int   cand;
  logic found;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(rr_last) + k) % N_REQ;
      if (!found && elig[cand]) begin
        found        = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/clusterv_main_sram_arb.sv
// Round-robin arbiter for the single port of the cluster main SRAM, with an
// optional timed lock that lets one requester run back-to-back atomic sequences.
module clusterv_main_sram_arb
  import clusterv_sram_arb_pkg::*;
#(
  parameter int N_REQ        = N_REQ_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input logic clock,
  input logic reset,
  clusterv_main_sram_arb_if.slave bus
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int BE_W  = DATA_W / 8;

  logic [IDX_W-1:0]      rr_last_q,   rr_last_d;
  logic                  rsp_pend_q,  rsp_pend_d;
  logic [IDX_W-1:0]      rsp_id_q,    rsp_id_d;
  logic                  lock_vld_q,  lock_vld_d;
  logic [IDX_W-1:0]      lock_id_q,   lock_id_d;
  logic [LOCK_CNT_W-1:0] lock_idle_q, lock_idle_d;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  // Reset gates eligibility so grants and strobes drop the instant reset asserts.
  always_comb begin
    elig = bus.rq_valid;
    if (lock_vld_q) begin
      elig            = '0;
      elig[lock_id_q] = bus.rq_valid[lock_id_q];
    end
    if (!reset) elig = '0;
  end

  clusterv_rr_arb #(.N_REQ(N_REQ)) u_rr (
    .elig    (elig),
    .rr_last (rr_last_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any = |gnt_oh;

  always_comb begin
    bus.rq_ready     = gnt_oh;
    bus.t_addr       = '0;
    bus.t_byte_en    = '0;
    bus.t_write_data = '0;
    bus.t_read_en    = 1'b0;
    bus.t_write_en   = 1'b0;
    if (gnt_any) begin
      bus.t_addr       = bus.rq_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      bus.t_byte_en    = bus.rq_byte_en[int'(gnt_idx)*BE_W +: BE_W];
      bus.t_write_data = bus.rq_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
      bus.t_write_en   = bus.rq_write[gnt_idx];
      bus.t_read_en    = ~bus.rq_write[gnt_idx];
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    if (rsp_pend_q) begin
      bus.rsp_valid[rsp_id_q] = 1'b1;
      bus.rsp_rdata           = bus.t_read_data;
    end
  end

  always_comb begin
    rr_last_d   = rr_last_q;
    rsp_pend_d  = gnt_any;
    rsp_id_d    = rsp_id_q;
    lock_vld_d  = lock_vld_q;
    lock_id_d   = lock_id_q;
    lock_idle_d = lock_idle_q;
    if (gnt_any) begin
      rr_last_d   = gnt_idx;
      rsp_id_d    = gnt_idx;
      lock_idle_d = '0;
      // While locked only lock_id can win, so a grant without rq_lock is the release.
      lock_vld_d  = bus.rq_lock[gnt_idx];
      if (bus.rq_lock[gnt_idx]) lock_id_d = gnt_idx;
    end else if (lock_vld_q) begin
      if (lock_idle_q == LOCK_CNT_W'(LOCK_TIMEOUT - 1)) begin
        lock_vld_d  = 1'b0;
        lock_idle_d = '0;
      end else begin
        lock_idle_d = lock_idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_last_q   <= IDX_W'(N_REQ - 1);
      rsp_pend_q  <= 1'b0;
      rsp_id_q    <= '0;
      lock_vld_q  <= 1'b0;
      lock_id_q   <= '0;
      lock_idle_q <= '0;
    end else begin
      rr_last_q   <= rr_last_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_id_q    <= rsp_id_d;
      lock_vld_q  <= lock_vld_d;
      lock_id_q   <= lock_id_d;
      lock_idle_q <= lock_idle_d;
    end
  end

endmodule

// File: tb/tb_clusterv_main_sram_arb.sv
// Directed bench for clusterv_main_sram_arb: a vector table for arbitration
// patterns plus hand-written lock, timeout, read-back and reset sequences.
module tb_clusterv_main_sram_arb;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clock;
  logic reset;

  clusterv_main_sram_arb_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  clusterv_main_sram_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model with a side preload port
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q;
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clock) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.t_write_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.t_byte_en[b]) mem[bus.t_addr][b*8 +: 8] <= bus.t_write_data[b*8 +: 8];
    end
    if (bus.t_read_en) rd_q <= mem[bus.t_addr];
  end
  assign bus.t_read_data = rd_q;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] write;
    logic [3:0] exp_ready;
    logic       exp_rd;
    logic       exp_wr;
    logic [3:0] exp_rsp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [3:0] l);
    bus.rq_valid = v;
    bus.rq_write = w;
    bus.rq_lock  = l;
  endtask

  task automatic set_req(input int i, input logic [9:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
    bus.rq_addr[i*AW +: AW]  = a;
    bus.rq_byte_en[i*4 +: 4] = be;
    bus.rq_wdata[i*DW +: DW] = wd;
  endtask

  task automatic table_fields();
    for (int i = 0; i < N; i++)
      set_req(i, 10'h100 + 10'(i), 4'b0001 << i, 32'hA000_0000 | 32'(i));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(4'b0, 4'b0, 4'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] act, exp;
    logic [9:0]  ea;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    int          g;

    reset = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.rq_addr = '0; bus.rq_byte_en = '0; bus.rq_wdata = '0;
    drive(4'b0, 4'b0, 4'b0);

    //            valid    write    ready    rd wr  rsp
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 1, 0, 4'b0000};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 1, 0, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 1, 0, 4'b0010};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 1, 0, 4'b0100};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 1, 0, 4'b1000};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0001};
    tbl[6]  = '{4'b1010, 4'b1010, 4'b0010, 0, 1, 4'b0000};
    tbl[7]  = '{4'b1010, 4'b1010, 4'b1000, 0, 1, 4'b0010};
    tbl[8]  = '{4'b0001, 4'b0000, 4'b0001, 1, 0, 4'b1000};
    tbl[9]  = '{4'b0110, 4'b0100, 4'b0010, 1, 0, 4'b0001};
    tbl[10] = '{4'b0101, 4'b0100, 4'b0100, 0, 1, 4'b0010};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0100};

    // Reset-state outputs with every requester valid
    table_fields();
    drive(4'b1111, 4'b0000, 4'b0000);
    #1;
    chk("reset_outputs", 64'({bus.rq_ready, bus.rsp_valid, bus.t_read_en, bus.t_write_en,
                             bus.t_addr, bus.t_byte_en, bus.t_write_data, bus.rsp_rdata}), 64'd0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(tbl[i].valid, tbl[i].write, 4'b0000);
      #1;
      ea = '0; ebe = '0; ewd = '0;
      if (tbl[i].exp_ready != 4'b0) begin
        g   = oh_idx(tbl[i].exp_ready);
        ea  = 10'h100 + 10'(g);
        ebe = 4'b0001 << g;
        ewd = 32'hA000_0000 | 32'(g);
      end
      act = {bus.rq_ready, bus.t_read_en, bus.t_write_en, bus.t_addr, bus.t_byte_en,
             bus.t_write_data, bus.rsp_valid};
      exp = {tbl[i].exp_ready, tbl[i].exp_rd, tbl[i].exp_wr, ea, ebe, ewd, tbl[i].exp_rsp};
      chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
    end

    // Single read of preloaded word
    preload(10'h005, 32'hDEADBEEF);
    do_reset();
    set_req(0, 10'h005, 4'hF, 32'h0);
    @(negedge clock); drive(4'b0001, 4'b0000, 4'b0000); #1;
    chk("rd_strobe", 64'({bus.rq_ready, bus.t_read_en, bus.t_write_en, bus.t_addr}),
        64'({4'b0001, 1'b1, 1'b0, 10'h005}));
    @(negedge clock); drive(4'b0000, 4'b0000, 4'b0000); #1;
    chk("rd_rsp", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'({4'b0001, 32'hDEADBEEF}));

    // Partial write then read-back at the top address
    preload(10'h3FF, 32'hAABBCCDD);
    do_reset();
    set_req(2, 10'h3FF, 4'b0101, 32'h11223344);
    @(negedge clock); drive(4'b0100, 4'b0100, 4'b0000); #1;
    chk("wr_strobe", 64'({bus.rq_ready, bus.t_write_en, bus.t_read_en, bus.t_addr,
                          bus.t_byte_en, bus.t_write_data}),
        64'({4'b0100, 1'b1, 1'b0, 10'h3FF, 4'b0101, 32'h11223344}));
    @(negedge clock); drive(4'b0100, 4'b0000, 4'b0000); #1;
    chk("wr_rsp_rd_grant", 64'({bus.rq_ready, bus.t_read_en, bus.rsp_valid}),
        64'({4'b0100, 1'b1, 4'b0100}));
    @(negedge clock); drive(4'b0000, 4'b0000, 4'b0000); #1;
    chk("readback", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'({4'b0100, 32'hAA22CC44}));

    // Locked read-modify-write by requester 1 while 0 and 3 compete
    do_reset();
    table_fields();
    @(negedge clock); drive(4'b0001, 4'b0000, 4'b0000); #1;
    chk("lk_pre", 64'(bus.rq_ready), 64'(4'b0001));
    @(negedge clock); drive(4'b1011, 4'b0000, 4'b0010); #1;
    chk("lk_read", 64'({bus.rq_ready, bus.t_read_en}), 64'({4'b0010, 1'b1}));
    @(negedge clock); drive(4'b1011, 4'b0010, 4'b0000); #1;
    chk("lk_write", 64'({bus.rq_ready, bus.t_write_en}), 64'({4'b0010, 1'b1}));
    @(negedge clock); drive(4'b1001, 4'b0000, 4'b0000); #1;
    chk("lk_after3", 64'(bus.rq_ready), 64'(4'b1000));
    @(negedge clock); drive(4'b1001, 4'b0000, 4'b0000); #1;
    chk("lk_after0", 64'(bus.rq_ready), 64'(4'b0001));

    // Lock abandoned: starve for LOCK_TIMEOUT cycles, then resume
    do_reset();
    @(negedge clock); drive(4'b0001, 4'b0000, 4'b0000); #1;
    chk("to_pre", 64'(bus.rq_ready), 64'(4'b0001));
    @(negedge clock); drive(4'b0011, 4'b0000, 4'b0010); #1;
    chk("to_lock", 64'(bus.rq_ready), 64'(4'b0010));
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock); drive(4'b0001, 4'b0000, 4'b0000); #1;
      chk($sformatf("to_idle%0d", k), 64'({bus.rq_ready, bus.t_read_en, bus.t_write_en}), 64'd0);
    end
    @(negedge clock); drive(4'b0001, 4'b0000, 4'b0000); #1;
    chk("to_resume", 64'(bus.rq_ready), 64'(4'b0001));

    // Reset with a locked read in flight
    do_reset();
    @(negedge clock); drive(4'b0100, 4'b0000, 4'b0100); #1;
    chk("rs_lock", 64'(bus.rq_ready), 64'(4'b0100));
    @(negedge clock); drive(4'b0100, 4'b0000, 4'b0100); #1;
    chk("rs_read", 64'({bus.rq_ready, bus.t_read_en}), 64'({4'b0100, 1'b1}));
    @(posedge clock); #1;
    reset = 1'b0;
    drive(4'b1111, 4'b0000, 4'b0000);
    #1;
    chk("rs_in_reset", 64'({bus.rq_ready, bus.rsp_valid, bus.t_read_en, bus.t_write_en,
                           bus.t_addr, bus.t_byte_en, bus.rsp_rdata}), 64'd0);
    @(negedge clock); #1;
    chk("rs_held", 64'({bus.rq_ready, bus.rsp_valid}), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rs_first", 64'({bus.rq_ready, bus.rsp_valid}), 64'({4'b0001, 4'b0000}));
    @(negedge clock); #1;
    chk("rs_second", 64'({bus.rq_ready, bus.rsp_valid}), 64'({4'b0010, 4'b0001}));

    drive(4'b0000, 4'b0000, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
